// File: rtl/score_tally_pkg.sv
// Shared defaults, converter state encoding and the BCD digit adjust helper
// used by the score tally and its binary-to-BCD converter.
package score_tally_pkg;

  localparam int DEF_BASE_POINTS = 10;
  localparam int DEF_MULT_STEP   = 8;
  localparam int DEF_MAX_MULT    = 4;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_LOAD  = 2'd1,
    CONV_SHIFT = 2'd2,
    CONV_DONE  = 2'd3
  } conv_state_t;

  function automatic logic [3:0] dabble_digit(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: LOAD snapshots bin, SHIFT runs SCORE_W
// cycles, DONE holds one cycle with the finished digits on bcd.
module bin2bcd_seq
  import score_tally_pkg::*;
#(
  parameter int SCORE_W = 17,
  parameter int DIGITS  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SCORE_W-1:0]  bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(SCORE_W + 1);

  conv_state_t         state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [SCORE_W-1:0]  bin_reg;
  logic [4*DIGITS-1:0] bcd_reg, bcd_adj;
  logic                last_shift;

  assign last_shift = (cnt == CNT_W'(SCORE_W - 1));

  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = dabble_digit(bcd_reg[4*i +: 4]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE:  if (start) state_nxt = CONV_LOAD;
      CONV_LOAD:  state_nxt = CONV_SHIFT;
      CONV_SHIFT: if (last_shift) state_nxt = CONV_DONE;
      CONV_DONE:  state_nxt = CONV_IDLE;
      default:    state_nxt = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CONV_IDLE;
      cnt     <= '0;
      bin_reg <= '0;
      bcd_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        CONV_LOAD: begin
          bin_reg <= bin;
          bcd_reg <= '0;
          cnt     <= '0;
        end
        CONV_SHIFT: begin
          // adjust every digit, then shift the next binary MSB into digit 0
          {bcd_reg, bin_reg} <= {bcd_adj[4*DIGITS-2:0], bin_reg, 1'b0};
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != CONV_IDLE);
  assign done = (state == CONV_DONE);
  assign bcd  = bcd_reg;

endmodule

// File: rtl/score_tally.sv
// Score, streak, multiplier and miss tracking with one credited hit per note
// window; keeps a BCD copy of the score refreshed by a background converter.
module score_tally
  import score_tally_pkg::*;
#(
  parameter int SCORE_W     = 17,
  parameter int STREAK_W    = 8,
  parameter int BASE_POINTS = DEF_BASE_POINTS,
  parameter int MULT_STEP   = DEF_MULT_STEP,
  parameter int MAX_MULT    = DEF_MAX_MULT,
  parameter int DIGITS      = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                hit,
  input  logic                window_end,
  input  logic                rest_window,
  output logic [SCORE_W-1:0]  score,
  output logic [STREAK_W-1:0] streak,
  output logic [2:0]          multiplier,
  output logic [7:0]          miss_count,
  output logic                streak_break,
  output logic [4*DIGITS-1:0] bcd_digits,
  output logic                bcd_valid
);

  localparam int                  PROD_W     = SCORE_W + 3;
  localparam logic [SCORE_W-1:0]  SCORE_MAX  = '1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

  logic                hit_seen, credit, miss, score_chg;
  logic                dirty, discard;
  logic [PROD_W-1:0]   award;
  logic [PROD_W:0]     score_sum;
  logic [SCORE_W-1:0]  score_nxt;
  logic [STREAK_W:0]   mult_calc;
  logic [2:0]          mult_nxt;
  logic                conv_start, conv_busy, conv_done;
  logic [4*DIGITS-1:0] conv_bcd;

  assign credit = hit && !hit_seen;
  assign miss   = window_end && !hit_seen && !hit && !rest_window;

  assign award     = PROD_W'(BASE_POINTS) * PROD_W'(multiplier);
  assign score_sum = {1'b0, PROD_W'(score)} + {1'b0, award};
  assign score_nxt = (score_sum > (PROD_W+1)'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
  assign score_chg = credit && (score_nxt != score);

  assign mult_calc = (STREAK_W+1)'(streak / STREAK_W'(MULT_STEP)) + (STREAK_W+1)'(1);
  assign mult_nxt  = (mult_calc >= (STREAK_W+1)'(MAX_MULT)) ? 3'(MAX_MULT) : mult_calc[2:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score        <= '0;
      streak       <= '0;
      multiplier   <= 3'd1;
      miss_count   <= '0;
      streak_break <= 1'b0;
      hit_seen     <= 1'b0;
    end else if (clear) begin
      score        <= '0;
      streak       <= '0;
      multiplier   <= 3'd1;
      miss_count   <= '0;
      streak_break <= 1'b0;
      hit_seen     <= 1'b0;
    end else begin
      if (credit) score <= score_nxt;
      if (credit) begin
        streak <= (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
      end else if (miss) begin
        streak <= '0;
      end
      // multiplier trails streak by one cycle, except a miss resets both together
      multiplier <= miss ? 3'd1 : mult_nxt;
      if (miss && (miss_count != 8'hFF)) miss_count <= miss_count + 8'd1;
      streak_break <= miss && (streak != '0);
      if (window_end) hit_seen <= 1'b0;
      else if (credit) hit_seen <= 1'b1;
    end
  end

  assign conv_start = dirty && !conv_busy;

  // discard drops the result of a conversion that was in flight across a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dirty      <= 1'b0;
      discard    <= 1'b0;
      bcd_valid  <= 1'b1;
      bcd_digits <= '0;
    end else if (clear) begin
      dirty      <= 1'b0;
      discard    <= conv_busy && !conv_done;
      bcd_valid  <= 1'b1;
      bcd_digits <= '0;
    end else begin
      if (score_chg) dirty <= 1'b1;
      else if (conv_start) dirty <= 1'b0;
      if (conv_done) discard <= 1'b0;
      if (conv_done && !discard) bcd_digits <= conv_bcd;
      if (score_chg) bcd_valid <= 1'b0;
      else if (conv_done && !discard && !dirty) bcd_valid <= 1'b1;
    end
  end

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (score),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

endmodule

// File: tb/tb_score_tally.sv
// Directed bench: default-parameter instance for scoring rules, saturating
// instance (BASE_POINTS=60000, MAX_MULT=1) for overflow and clear-abort cases.
module tb_score_tally;

  localparam int LAT = 17 + 3;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        clr = 1'b0, hit = 1'b0, we = 1'b0, rest = 1'b0;
  logic [16:0] score;
  logic [7:0]  streak, miss_count;
  logic [2:0]  mult;
  logic        brk, bcd_valid;
  logic [23:0] bcd_digits;

  logic        s_clr = 1'b0, s_hit = 1'b0, s_we = 1'b0, s_rest = 1'b0;
  logic [16:0] s_score;
  logic [7:0]  s_streak, s_miss_count;
  logic [2:0]  s_mult;
  logic        s_brk, s_bcd_valid;
  logic [23:0] s_bcd_digits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_tally dut (
    .clk(clk), .reset(reset), .clear(clr), .hit(hit), .window_end(we), .rest_window(rest),
    .score(score), .streak(streak), .multiplier(mult), .miss_count(miss_count),
    .streak_break(brk), .bcd_digits(bcd_digits), .bcd_valid(bcd_valid)
  );

  score_tally #(.BASE_POINTS(60000), .MAX_MULT(1)) dut_sat (
    .clk(clk), .reset(reset), .clear(s_clr), .hit(s_hit), .window_end(s_we), .rest_window(s_rest),
    .score(s_score), .streak(s_streak), .multiplier(s_mult), .miss_count(s_miss_count),
    .streak_break(s_brk), .bcd_digits(s_bcd_digits), .bcd_valid(s_bcd_valid)
  );

  typedef struct {
    logic        clr, hit, we, rest;
    logic [16:0] score;
    logic [7:0]  streak;
    logic [2:0]  mult;
    logic [7:0]  miss;
    logic        brk;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic c, input logic h, input logic w, input logic r,
                              input int sc, input int st, input int m, input int mi, input logic b);
    vec_t v;
    v.clr = c; v.hit = h; v.we = w; v.rest = r;
    v.score = 17'(sc); v.streak = 8'(st); v.mult = 3'(m); v.miss = 8'(mi); v.brk = b;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // inputs are applied after a negedge; on return the next negedge has passed
  task automatic step_a(input logic c, input logic h, input logic w, input logic r);
    clr = c; hit = h; we = w; rest = r;
    @(negedge clk);
  endtask

  task automatic step_b(input logic c, input logic h, input logic w, input logic r);
    s_clr = c; s_hit = h; s_we = w; s_rest = r;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit bad;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst score", 32'(score), 0);
    chk("rst streak", 32'(streak), 0);
    chk("rst mult", 32'(mult), 1);
    chk("rst miss", 32'(miss_count), 0);
    chk("rst brk", 32'(brk), 0);
    chk("rst bcd", 32'(bcd_digits), 0);
    chk("rst bcd_valid", 32'(bcd_valid), 1);
    reset = 1'b1;

    // repeated hits in one window credit once; BCD ready LAT cycles later
    step_a(0, 0, 0, 0);
    step_a(0, 0, 0, 0);
    step_a(0, 1, 0, 0);
    chk("t2 score", 32'(score), 10);
    chk("t2 streak", 32'(streak), 1);
    chk("t2 valid drop", 32'(bcd_valid), 0);
    for (int k = 1; k <= LAT; k++) begin
      step_a(0, (k == 2) || (k == 4), (k == 6), 0);
      if (k == 6) begin
        chk("t2 score after window", 32'(score), 10);
        chk("t2 streak after window", 32'(streak), 1);
        chk("t2 no miss", 32'(miss_count), 0);
        chk("t2 no brk", 32'(brk), 0);
      end
      if (k == LAT - 1) chk("t2 valid early", 32'(bcd_valid), 0);
    end
    chk("t2 valid at latency", 32'(bcd_valid), 1);
    chk("t2 bcd", 32'(bcd_digits), 32'h000010);

    // clr hit we rest | score streak mult miss brk
    add(1, 0, 0, 0,   0, 0, 1, 0, 0);
    add(0, 1, 0, 0,  10, 1, 1, 0, 0);  add(0, 0, 1, 0,  10, 1, 1, 0, 0);
    add(0, 1, 0, 0,  20, 2, 1, 0, 0);  add(0, 0, 1, 0,  20, 2, 1, 0, 0);
    add(0, 1, 0, 0,  30, 3, 1, 0, 0);  add(0, 0, 1, 0,  30, 3, 1, 0, 0);
    add(0, 1, 0, 0,  40, 4, 1, 0, 0);  add(0, 0, 1, 0,  40, 4, 1, 0, 0);
    add(0, 1, 0, 0,  50, 5, 1, 0, 0);  add(0, 0, 1, 0,  50, 5, 1, 0, 0);
    add(0, 1, 0, 0,  60, 6, 1, 0, 0);  add(0, 0, 1, 0,  60, 6, 1, 0, 0);
    add(0, 1, 0, 0,  70, 7, 1, 0, 0);  add(0, 0, 1, 0,  70, 7, 1, 0, 0);
    add(0, 1, 0, 0,  80, 8, 1, 0, 0);  add(0, 0, 1, 0,  80, 8, 2, 0, 0);
    add(0, 1, 0, 0, 100, 9, 2, 0, 0);  add(0, 0, 1, 0, 100, 9, 2, 0, 0);
    add(0, 0, 1, 0, 100, 0, 1, 1, 1);
    add(0, 0, 0, 0, 100, 0, 1, 1, 0);
    add(0, 1, 0, 0, 110, 1, 1, 1, 0);
    add(0, 0, 1, 0, 110, 1, 1, 1, 0);
    add(0, 0, 1, 1, 110, 1, 1, 1, 0);
    add(0, 1, 1, 0, 120, 2, 1, 1, 0);
    add(0, 1, 0, 0, 130, 3, 1, 1, 0);
    add(0, 0, 1, 0, 130, 3, 1, 1, 0);
    add(0, 0, 1, 0, 130, 0, 1, 2, 1);
    add(0, 0, 1, 0, 130, 0, 1, 3, 0);
    add(1, 1, 1, 0,   0, 0, 1, 0, 0);

    foreach (tbl[i]) begin
      step_a(tbl[i].clr, tbl[i].hit, tbl[i].we, tbl[i].rest);
      chk($sformatf("row%0d score", i), 32'(score), 32'(tbl[i].score));
      chk($sformatf("row%0d streak", i), 32'(streak), 32'(tbl[i].streak));
      chk($sformatf("row%0d mult", i), 32'(mult), 32'(tbl[i].mult));
      chk($sformatf("row%0d miss", i), 32'(miss_count), 32'(tbl[i].miss));
      chk($sformatf("row%0d brk", i), 32'(brk), 32'(tbl[i].brk));
    end
    step_a(0, 0, 0, 0);

    // saturation with a hit landing mid-conversion
    step_b(0, 1, 0, 0);
    chk("sat hit1", 32'(s_score), 60000);
    step_b(0, 0, 1, 0);
    step_b(0, 1, 0, 0);
    chk("sat hit2", 32'(s_score), 120000);
    step_b(0, 0, 1, 0);
    repeat (5) step_b(0, 0, 0, 0);
    step_b(0, 1, 0, 0);
    chk("sat hit3", 32'(s_score), 131071);
    chk("sat valid low", 32'(s_bcd_valid), 0);
    step_b(0, 0, 1, 0);
    found = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step_b(0, 0, 0, 0);
      if (s_bcd_digits != 24'h000000 && s_bcd_digits != 24'h060000 && s_bcd_digits != 24'h131071)
        bad = 1'b1;
      if (s_bcd_valid) found = 1'b1;
    end
    chk("sat valid within bound", 32'(found), 1);
    chk("sat no partial digits", 32'(bad), 0);
    chk("sat bcd", 32'(s_bcd_digits), 32'h131071);

    // clear aborts an in-flight conversion
    step_b(1, 0, 0, 0);
    chk("sat clear score", 32'(s_score), 0);
    step_b(0, 1, 0, 0);
    chk("sat rehit score", 32'(s_score), 60000);
    repeat (5) step_b(0, 0, 0, 0);
    step_b(1, 0, 0, 0);
    chk("clr score", 32'(s_score), 0);
    chk("clr streak", 32'(s_streak), 0);
    chk("clr mult", 32'(s_mult), 1);
    chk("clr miss", 32'(s_miss_count), 0);
    chk("clr brk", 32'(s_brk), 0);
    chk("clr bcd", 32'(s_bcd_digits), 0);
    chk("clr valid", 32'(s_bcd_valid), 1);
    bad = 1'b0;
    repeat (30) begin
      step_b(0, 0, 0, 0);
      if (s_bcd_valid !== 1'b1 || s_bcd_digits !== 24'h0) bad = 1'b1;
    end
    chk("clr stale result dropped", 32'(bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
